// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: sequences the FF46 OAM DMA copy (page XX00 -> FE00, one byte per
// machine cycle) and arbitrates the OAM bus with fixed priority DMA > PPU scan > CPU.
module oam_dma_arbiter #(
  parameter int NUM_BYTES   = 160,
  parameter int START_DELAY = 1,
  parameter int MCYCLE      = 4
) (
  input  logic        clk2,
  input  logic        nreset9,
  inout  wire  [7:0]  d,
  input  logic        cpu_wr_ff46,
  input  logic        cpu_rd_ff46,
  output logic [15:0] src_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_data,
  input  logic        ppu_scan,
  input  logic [7:0]  ppu_addr,
  input  logic        cpu_oam_req,
  input  logic        cpu_oam_wr,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic [7:0]  oam_q,
  output logic [7:0]  cpu_oam_q,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_din,
  output logic        oam_wr,
  output logic        grant_ppu,
  output logic        grant_cpu,
  output logic        dma_active
);

  localparam int PW = (MCYCLE > 1) ? $clog2(MCYCLE) : 1;
  localparam int DW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(MCYCLE - 1);
  localparam logic [7:0]    LAST_BYTE  = 8'(NUM_BYTES - 1);
  localparam logic [DW-1:0] DELAY_INIT = DW'(START_DELAY);

  typedef enum logic [1:0] {IDLE, ARMED, XFER} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase;
  logic [7:0]    page;
  logic [7:0]    byte_cnt, byte_cnt_nxt;
  logic [7:0]    xfer_hi, xfer_hi_nxt;
  logic [DW-1:0] delay, delay_nxt;
  logic          copying, copying_nxt;
  logic          carry_active, carry_active_nxt;
  logic          mc_end;
  logic          moving;
  logic [7:0]    src_hi;

  assign mc_end = (phase == LAST_PHASE);
  // A restarted transfer keeps copying its old bytes while the new one is armed.
  assign moving = (state == XFER) || ((state == ARMED) && copying);
  assign src_hi = (page < 8'hE0) ? page : (page - 8'h20);
  assign dma_active = (state == XFER) || ((state == ARMED) && carry_active);
  assign d = (nreset9 && cpu_rd_ff46) ? page : 8'hzz;

  always_ff @(posedge clk2 or negedge nreset9) begin
    if (!nreset9) begin
      state        <= IDLE;
      phase        <= '0;
      page         <= 8'hFF;
      byte_cnt     <= '0;
      xfer_hi      <= '0;
      delay        <= '0;
      copying      <= 1'b0;
      carry_active <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase        <= mc_end ? '0 : (phase + PW'(1));
      byte_cnt     <= byte_cnt_nxt;
      xfer_hi      <= xfer_hi_nxt;
      delay        <= delay_nxt;
      copying      <= copying_nxt;
      carry_active <= carry_active_nxt;
      if (cpu_wr_ff46) begin
        page <= d;
      end
    end
  end

  // Machine-cycle boundaries fall on the last phase; the FF46 write overrides everything.
  always_comb begin
    state_nxt        = state;
    byte_cnt_nxt     = byte_cnt;
    xfer_hi_nxt      = xfer_hi;
    delay_nxt        = delay;
    copying_nxt      = copying;
    carry_active_nxt = carry_active;

    if (moving && mc_end) begin
      byte_cnt_nxt = byte_cnt + 8'd1;
      if (byte_cnt == LAST_BYTE) begin
        byte_cnt_nxt = '0;
        copying_nxt  = 1'b0;
        if (state == XFER) begin
          state_nxt = IDLE;
        end
      end
    end

    if ((state == ARMED) && mc_end) begin
      if (delay == '0) begin
        state_nxt        = XFER;
        byte_cnt_nxt     = '0;
        xfer_hi_nxt      = src_hi;
        copying_nxt      = 1'b0;
        carry_active_nxt = 1'b0;
      end else begin
        delay_nxt = delay - DW'(1);
      end
    end

    if (cpu_wr_ff46) begin
      state_nxt = ARMED;
      delay_nxt = DELAY_INIT;
      if (state == XFER) begin
        carry_active_nxt = 1'b1;
        copying_nxt      = !(mc_end && (byte_cnt == LAST_BYTE));
      end else if (state == IDLE) begin
        carry_active_nxt = 1'b0;
        copying_nxt      = 1'b0;
      end
    end
  end

  // Requester inputs are masked while reset is low so every output sits at its reset value.
  always_comb begin
    src_addr  = '0;
    dma_rd    = 1'b0;
    oam_addr  = '0;
    oam_din   = '0;
    oam_wr    = 1'b0;
    grant_ppu = 1'b0;
    grant_cpu = 1'b0;
    cpu_oam_q = 8'hFF;

    if (dma_active) begin
      if (moving) begin
        if (mc_end) begin
          oam_addr = byte_cnt;
          oam_din  = dma_data;
          oam_wr   = 1'b1;
        end else begin
          dma_rd   = 1'b1;
          src_addr = {xfer_hi, byte_cnt};
        end
      end
    end else if (nreset9) begin
      if (ppu_scan) begin
        grant_ppu = 1'b1;
        oam_addr  = ppu_addr;
      end else if (cpu_oam_req) begin
        grant_cpu = 1'b1;
        oam_addr  = cpu_addr;
        cpu_oam_q = oam_q;
        if (cpu_oam_wr) begin
          oam_din = cpu_din;
          oam_wr  = 1'b1;
        end
      end
    end
  end

endmodule
